// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: id type, entry payload struct and pointer helpers.
package rob_pkg;

   localparam int unsigned PC_W      = 39;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned LREG_W    = 5;
   localparam int unsigned PREG_W    = 7;
   localparam int unsigned ROB_DEPTH = 32;
   localparam int unsigned ROB_ID_W  = $clog2(ROB_DEPTH) + 1;

   typedef logic [ROB_ID_W-1:0] robid_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [LREG_W-1:0]  lrd;
      logic [PREG_W-1:0]  prd;
      logic [PREG_W-1:0]  old_prd;
      logic               need_to_wb;
      logic               skip;
   } rob_entry_t;

   // Wraps naturally modulo 2*DEPTH because the id carries one extra wrap bit.
   function automatic robid_t ptr_add(robid_t p, robid_t n);
      return p + n;
   endfunction

   // True when a is older than b in program order.
   function automatic logic ptr_lt(robid_t a, robid_t b);
      if (a[ROB_ID_W-1] == b[ROB_ID_W-1]) begin
         return a[ROB_ID_W-2:0] < b[ROB_ID_W-2:0];
      end
      return a[ROB_ID_W-2:0] > b[ROB_ID_W-2:0];
   endfunction

endpackage

// File: rtl/rob_slot.sv
// One reorder-buffer entry: valid/complete flags, lap flag and payload.
module rob_slot
   import rob_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  logic       alloc,
   input  logic       alloc_flag,
   input  logic       alloc_complete,
   input  rob_entry_t alloc_entry,
   input  logic       wb_hit,
   input  logic       wb_skip,
   input  logic       retire,
   output logic       valid,
   output logic       complete,
   output logic       flag,
   output rob_entry_t entry
);

   logic       valid_q;
   logic       complete_q;
   logic       flag_q;
   rob_entry_t entry_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q    <= 1'b0;
         complete_q <= 1'b0;
         flag_q     <= 1'b0;
         entry_q    <= '0;
      end else if (flush) begin
         valid_q    <= 1'b0;
         complete_q <= 1'b0;
      end else if (alloc) begin
         valid_q    <= 1'b1;
         complete_q <= alloc_complete;
         flag_q     <= alloc_flag;
         entry_q    <= alloc_entry;
      end else begin
         if (wb_hit) begin
            complete_q    <= 1'b1;
            entry_q.skip  <= wb_skip;
         end
         if (retire) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid    = valid_q;
   assign complete = complete_q;
   assign flag     = flag_q;
   assign entry    = entry_q;

endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: in-order multi-lane allocate, out-of-order writeback, in-order multi-lane retire.
module rob_queue
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned ENQ_W   = 2,
   parameter int unsigned WB_W    = 4,
   parameter int unsigned CMT_W   = 2,
   parameter int unsigned ROBID_W = $clog2(DEPTH) + 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [ENQ_W-1:0]           enq_valid,
   input  logic [ENQ_W*PC_W-1:0]      enq_pc,
   input  logic [ENQ_W*INSTR_W-1:0]   enq_instr,
   input  logic [ENQ_W*LREG_W-1:0]    enq_lrd,
   input  logic [ENQ_W*PREG_W-1:0]    enq_prd,
   input  logic [ENQ_W*PREG_W-1:0]    enq_old_prd,
   input  logic [ENQ_W-1:0]           enq_need_to_wb,
   output logic                       enq_ready,
   output logic [ENQ_W*ROBID_W-1:0]   enq_robid,
   input  logic [WB_W-1:0]            wb_valid,
   input  logic [WB_W*ROBID_W-1:0]    wb_robid,
   input  logic [WB_W-1:0]            wb_skip,
   output logic [CMT_W-1:0]           cmt_valid,
   output logic [CMT_W*PC_W-1:0]      cmt_pc,
   output logic [CMT_W*INSTR_W-1:0]   cmt_instr,
   output logic [CMT_W*LREG_W-1:0]    cmt_lrd,
   output logic [CMT_W*PREG_W-1:0]    cmt_prd,
   output logic [CMT_W*PREG_W-1:0]    cmt_old_prd,
   output logic [CMT_W-1:0]           cmt_need_to_wb,
   output logic [CMT_W-1:0]           cmt_skip,
   input  logic                       flush,
   output logic                       empty,
   output logic                       full,
   output logic [ROBID_W-1:0]         count
);

   localparam int unsigned IDX_W = ROBID_W - 1;

   logic [ROBID_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [ROBID_W-1:0] enq_num, cmt_num;
   logic [ROBID_W-1:0] lane_id [ENQ_W];
   logic [ROBID_W-1:0] cmt_id  [CMT_W];
   logic [ENQ_W-1:0]   enq_lane;
   logic               enq_fire;

   logic [DEPTH-1:0] slot_valid, slot_complete, slot_flag;
   logic [DEPTH-1:0] slot_alloc, slot_alloc_flag, slot_alloc_cpl;
   logic [DEPTH-1:0] slot_wb_hit, slot_wb_skip, slot_retire;
   rob_entry_t       slot_entry       [DEPTH];
   rob_entry_t       slot_alloc_entry [DEPTH];

   // Free space comes from the registered count only; same-cycle retires do not help.
   always_comb begin
      enq_ready = count_q <= ROBID_W'(DEPTH - ENQ_W);
      enq_fire  = enq_ready & enq_valid[0] & ~flush;
      enq_lane  = enq_fire ? enq_valid : '0;
      enq_num   = '0;
      for (int k = 0; k < ENQ_W; k++) begin
         lane_id[k]                       = tail_q + ROBID_W'(k);
         enq_robid[k*ROBID_W +: ROBID_W]  = lane_id[k];
         enq_num                          = enq_num + ROBID_W'(enq_lane[k]);
      end
   end

   always_comb begin
      logic chain;
      chain          = ~flush;
      cmt_num        = '0;
      cmt_valid      = '0;
      cmt_pc         = '0;
      cmt_instr      = '0;
      cmt_lrd        = '0;
      cmt_prd        = '0;
      cmt_old_prd    = '0;
      cmt_need_to_wb = '0;
      cmt_skip       = '0;
      for (int k = 0; k < CMT_W; k++) begin
         cmt_id[k] = head_q + ROBID_W'(k);
         chain     = chain & slot_valid[cmt_id[k][IDX_W-1:0]]
                           & slot_complete[cmt_id[k][IDX_W-1:0]];
         cmt_valid[k]                       = chain;
         cmt_num                            = cmt_num + ROBID_W'(chain);
         cmt_pc[k*PC_W +: PC_W]             = slot_entry[cmt_id[k][IDX_W-1:0]].pc;
         cmt_instr[k*INSTR_W +: INSTR_W]    = slot_entry[cmt_id[k][IDX_W-1:0]].instr;
         cmt_lrd[k*LREG_W +: LREG_W]        = slot_entry[cmt_id[k][IDX_W-1:0]].lrd;
         cmt_prd[k*PREG_W +: PREG_W]        = slot_entry[cmt_id[k][IDX_W-1:0]].prd;
         cmt_old_prd[k*PREG_W +: PREG_W]    = slot_entry[cmt_id[k][IDX_W-1:0]].old_prd;
         cmt_need_to_wb[k]                  = slot_entry[cmt_id[k][IDX_W-1:0]].need_to_wb;
         cmt_skip[k]                        = slot_entry[cmt_id[k][IDX_W-1:0]].skip;
      end
   end

   // Per-slot decode of allocate lanes, writeback ports (full id incl. lap flag) and retire lanes.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_alloc[i]       = 1'b0;
         slot_alloc_flag[i]  = 1'b0;
         slot_alloc_cpl[i]   = 1'b0;
         slot_alloc_entry[i] = '0;
         slot_wb_hit[i]      = 1'b0;
         slot_wb_skip[i]     = 1'b0;
         slot_retire[i]      = 1'b0;
         for (int k = 0; k < ENQ_W; k++) begin
            if (enq_lane[k] && lane_id[k][IDX_W-1:0] == IDX_W'(i)) begin
               slot_alloc[i]                  = 1'b1;
               slot_alloc_flag[i]             = lane_id[k][IDX_W];
               slot_alloc_cpl[i]              = ~enq_need_to_wb[k];
               slot_alloc_entry[i].pc         = enq_pc[k*PC_W +: PC_W];
               slot_alloc_entry[i].instr      = enq_instr[k*INSTR_W +: INSTR_W];
               slot_alloc_entry[i].lrd        = enq_lrd[k*LREG_W +: LREG_W];
               slot_alloc_entry[i].prd        = enq_prd[k*PREG_W +: PREG_W];
               slot_alloc_entry[i].old_prd    = enq_old_prd[k*PREG_W +: PREG_W];
               slot_alloc_entry[i].need_to_wb = enq_need_to_wb[k];
            end
         end
         for (int p = 0; p < WB_W; p++) begin
            if (wb_valid[p] && slot_valid[i] &&
                wb_robid[p*ROBID_W +: ROBID_W] == {slot_flag[i], IDX_W'(i)}) begin
               slot_wb_hit[i]  = 1'b1;
               slot_wb_skip[i] = wb_skip[p];
            end
         end
         for (int k = 0; k < CMT_W; k++) begin
            if (cmt_valid[k] && cmt_id[k][IDX_W-1:0] == IDX_W'(i)) begin
               slot_retire[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      head_d  = head_q + cmt_num;
      tail_d  = tail_q + enq_num;
      count_d = count_q + enq_num - cmt_num;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign empty = head_q == tail_q;
   assign full  = (head_q[IDX_W] != tail_q[IDX_W]) && (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
   assign count = count_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      rob_slot u_slot (
         .clock          (clock),
         .reset          (reset),
         .flush          (flush),
         .alloc          (slot_alloc[i]),
         .alloc_flag     (slot_alloc_flag[i]),
         .alloc_complete (slot_alloc_cpl[i]),
         .alloc_entry    (slot_alloc_entry[i]),
         .wb_hit         (slot_wb_hit[i]),
         .wb_skip        (slot_wb_skip[i]),
         .retire         (slot_retire[i]),
         .valid          (slot_valid[i]),
         .complete       (slot_complete[i]),
         .flag           (slot_flag[i]),
         .entry          (slot_entry[i])
      );
   end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: allocate, writeback ordering, full, wrap, flush and reset.
module tb_rob_queue;
   import rob_pkg::*;

   localparam int RW = 6;

   logic                clock = 1'b0;
   logic                reset;
   logic [1:0]          enq_valid;
   logic [2*PC_W-1:0]   enq_pc;
   logic [2*INSTR_W-1:0] enq_instr;
   logic [2*LREG_W-1:0] enq_lrd;
   logic [2*PREG_W-1:0] enq_prd, enq_old_prd;
   logic [1:0]          enq_need_to_wb;
   logic                enq_ready;
   logic [2*RW-1:0]     enq_robid;
   logic [3:0]          wb_valid;
   logic [4*RW-1:0]     wb_robid;
   logic [3:0]          wb_skip;
   logic [1:0]          cmt_valid;
   logic [2*PC_W-1:0]   cmt_pc;
   logic [2*INSTR_W-1:0] cmt_instr;
   logic [2*LREG_W-1:0] cmt_lrd;
   logic [2*PREG_W-1:0] cmt_prd, cmt_old_prd;
   logic [1:0]          cmt_need_to_wb, cmt_skip;
   logic                flush, empty, full;
   logic [RW-1:0]       count;

   int n_tests = 0;
   int n_fail  = 0;

   rob_queue dut (
      .clock          (clock),
      .reset          (reset),
      .enq_valid      (enq_valid),
      .enq_pc         (enq_pc),
      .enq_instr      (enq_instr),
      .enq_lrd        (enq_lrd),
      .enq_prd        (enq_prd),
      .enq_old_prd    (enq_old_prd),
      .enq_need_to_wb (enq_need_to_wb),
      .enq_ready      (enq_ready),
      .enq_robid      (enq_robid),
      .wb_valid       (wb_valid),
      .wb_robid       (wb_robid),
      .wb_skip        (wb_skip),
      .cmt_valid      (cmt_valid),
      .cmt_pc         (cmt_pc),
      .cmt_instr      (cmt_instr),
      .cmt_lrd        (cmt_lrd),
      .cmt_prd        (cmt_prd),
      .cmt_old_prd    (cmt_old_prd),
      .cmt_need_to_wb (cmt_need_to_wb),
      .cmt_skip       (cmt_skip),
      .flush          (flush),
      .empty          (empty),
      .full           (full),
      .count          (count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      enq_valid      = '0;
      enq_pc         = '0;
      enq_instr      = '0;
      enq_lrd        = '0;
      enq_prd        = '0;
      enq_old_prd    = '0;
      enq_need_to_wb = '0;
      wb_valid       = '0;
      wb_robid       = '0;
      wb_skip        = '0;
      flush          = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic enq2(input int pc0, input logic nw);
      enq_valid      = 2'b11;
      enq_pc         = {PC_W'(pc0 + 4), PC_W'(pc0)};
      enq_instr      = {INSTR_W'(pc0 + 1), INSTR_W'(pc0)};
      enq_need_to_wb = {nw, nw};
   endtask

   task automatic wb(input int p, input int id, input logic sk);
      wb_valid[p]          = 1'b1;
      wb_robid[p*RW +: RW] = RW'(id);
      wb_skip[p]           = sk;
   endtask

   function automatic logic [2*RW-1:0] rid2(input int a);
      return {RW'(a + 1), RW'(a)};
   endfunction

   function automatic logic [2*PC_W-1:0] pc2(input int a);
      return {PC_W'(a + 4), PC_W'(a)};
   endfunction

   initial begin
      clear_in();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_empty", 128'(empty), 128'(1'b1));
      check("rst_full", 128'(full), 128'(1'b0));
      check("rst_ready", 128'(enq_ready), 128'(1'b1));
      check("rst_count", 128'(count), 128'(0));
      check("rst_robid", 128'(enq_robid), 128'(rid2(0)));
      check("rst_cmt_valid", 128'(cmt_valid), 128'(2'b00));
      check("rst_cmt_pc", 128'(cmt_pc), 128'(0));

      // Two complete-at-allocate entries commit the next cycle
      enq2(32'h100, 1'b0);
      tick();
      clear_in();
      check("t1_count", 128'(count), 128'(2));
      check("t1_cmt_valid", 128'(cmt_valid), 128'(2'b11));
      check("t1_cmt_pc", 128'(cmt_pc), 128'(pc2(32'h100)));
      tick();
      check("t1_count_after", 128'(count), 128'(0));
      check("t1_empty_after", 128'(empty), 128'(1'b1));
      check("t1_cmt_idle", 128'(cmt_valid), 128'(2'b00));

      // Out-of-order writeback, in-order retire
      do_reset();
      enq2(32'h200, 1'b1);
      tick();
      enq2(32'h208, 1'b1);
      check("t2_robid", 128'(enq_robid), 128'(rid2(2)));
      tick();
      clear_in();
      wb(0, 3, 1'b0);
      wb(1, 2, 1'b0);
      wb(2, 1, 1'b0);
      tick();
      clear_in();
      check("t2_no_cmt", 128'(cmt_valid), 128'(2'b00));
      check("t2_count", 128'(count), 128'(4));
      wb(0, 0, 1'b1);
      tick();
      clear_in();
      check("t2_cmt01", 128'(cmt_valid), 128'(2'b11));
      check("t2_pc01", 128'(cmt_pc), 128'(pc2(32'h200)));
      check("t2_skip01", 128'(cmt_skip), 128'(2'b01));
      check("t2_nw01", 128'(cmt_need_to_wb), 128'(2'b11));
      tick();
      check("t2_cmt23", 128'(cmt_valid), 128'(2'b11));
      check("t2_pc23", 128'(cmt_pc), 128'(pc2(32'h208)));
      check("t2_skip23", 128'(cmt_skip), 128'(2'b00));
      tick();
      check("t2_empty", 128'(empty), 128'(1'b1));

      // Fill to full starting from head = tail = 4
      for (int i = 0; i < 16; i++) begin
         check("t3_ready_fill", 128'(enq_ready), 128'(1'b1));
         enq2(32'h1000 + 8 * i, 1'b1);
         tick();
      end
      clear_in();
      check("t3_full", 128'(full), 128'(1'b1));
      check("t3_ready", 128'(enq_ready), 128'(1'b0));
      check("t3_count", 128'(count), 128'(32));
      check("t3_robid", 128'(enq_robid), 128'(rid2(36)));
      enq2(32'h3000, 1'b0);
      tick();
      clear_in();
      check("t3_count_ign", 128'(count), 128'(32));
      check("t3_robid_ign", 128'(enq_robid), 128'(rid2(36)));

      // Count 31 is not enough room for two lanes
      do_reset();
      for (int i = 0; i < 15; i++) begin
         enq2(32'h4000 + 8 * i, 1'b1);
         tick();
      end
      clear_in();
      check("t3b_ready30", 128'(enq_ready), 128'(1'b1));
      enq_valid = 2'b01;
      enq_need_to_wb = 2'b01;
      tick();
      clear_in();
      check("t3b_count31", 128'(count), 128'(31));
      check("t3b_ready31", 128'(enq_ready), 128'(1'b0));
      check("t3b_full31", 128'(full), 128'(1'b0));
      enq2(32'h5000, 1'b0);
      tick();
      clear_in();
      check("t3b_count_ign", 128'(count), 128'(31));
      check("t3b_robid_ign", 128'(enq_robid), 128'(rid2(31)));

      // Wrap-around: advance head/tail to 30, then straddle the lap boundary
      do_reset();
      for (int i = 0; i < 15; i++) begin
         enq2(32'h6000 + 8 * i, 1'b0);
         tick();
      end
      clear_in();
      tick();
      check("t4_empty30", 128'(empty), 128'(1'b1));
      check("t4_robid30", 128'(enq_robid), 128'(rid2(30)));
      enq2(32'h7000, 1'b1);
      tick();
      enq2(32'h7008, 1'b1);
      check("t4_robid32", 128'(enq_robid), 128'(rid2(32)));
      tick();
      clear_in();
      check("t4_count", 128'(count), 128'(4));
      check("t4_robid34", 128'(enq_robid), 128'(rid2(34)));
      check("t4_full", 128'(full), 128'(1'b0));
      wb(0, 0, 1'b0);
      wb(1, 1, 1'b0);
      tick();
      clear_in();
      check("t4_stale_nocmt", 128'(cmt_valid), 128'(2'b00));
      wb(0, 30, 1'b0);
      wb(1, 31, 1'b0);
      tick();
      clear_in();
      check("t4_cmt3031", 128'(cmt_valid), 128'(2'b11));
      check("t4_pc3031", 128'(cmt_pc), 128'(pc2(32'h7000)));
      tick();
      check("t4_stale_ign", 128'(cmt_valid), 128'(2'b00));
      check("t4_count2", 128'(count), 128'(2));
      wb(2, 32, 1'b0);
      wb(3, 33, 1'b1);
      tick();
      clear_in();
      check("t4_cmt3233", 128'(cmt_valid), 128'(2'b11));
      check("t4_pc3233", 128'(cmt_pc), 128'(pc2(32'h7008)));
      check("t4_skip3233", 128'(cmt_skip), 128'(2'b10));
      tick();
      check("t4_empty34", 128'(empty), 128'(1'b1));

      // Flush with 10 pending entries plus same-cycle enqueue and writeback
      for (int i = 0; i < 5; i++) begin
         enq2(32'h8000 + 8 * i, 1'b1);
         tick();
      end
      clear_in();
      wb(0, 34, 1'b0);
      wb(1, 35, 1'b0);
      tick();
      clear_in();
      check("t5_count10", 128'(count), 128'(10));
      check("t5_precmt", 128'(cmt_valid), 128'(2'b11));
      flush = 1'b1;
      enq2(32'h9000, 1'b0);
      wb(0, 36, 1'b0);
      #1;
      check("t5_flush_cmt", 128'(cmt_valid), 128'(2'b00));
      tick();
      clear_in();
      check("t5_empty", 128'(empty), 128'(1'b1));
      check("t5_count", 128'(count), 128'(0));
      check("t5_robid", 128'(enq_robid), 128'(rid2(0)));
      check("t5_cmt_after", 128'(cmt_valid), 128'(2'b00));

      // Reset while half full
      for (int i = 0; i < 8; i++) begin
         enq2(32'hA000 + 8 * i, 1'b1);
         tick();
      end
      clear_in();
      check("t6_count16", 128'(count), 128'(16));
      reset = 1'b1;
      enq2(32'hB000, 1'b0);
      wb(0, 0, 1'b1);
      tick();
      reset = 1'b0;
      clear_in();
      check("t6_empty", 128'(empty), 128'(1'b1));
      check("t6_full", 128'(full), 128'(1'b0));
      check("t6_count", 128'(count), 128'(0));
      check("t6_ready", 128'(enq_ready), 128'(1'b1));
      check("t6_robid", 128'(enq_robid), 128'(rid2(0)));
      check("t6_cmt_valid", 128'(cmt_valid), 128'(2'b00));
      check("t6_cmt_pc", 128'(cmt_pc), 128'(0));
      check("t6_cmt_skip", 128'(cmt_skip), 128'(2'b00));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
